mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the execute stage and the write-back stage. It registers the EXE→MEM bus, drives the synchronous data RAM, and detects load/store address errors. It performs byte/half/word alignment and extension, then presents the 156-bit MEM→WB bus that the write-back stage decodes. It owns its own valid/allow-in handshake and a two-state FSM that stalls loads for the RAM read latency.

---
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Pipeline handshake and bus bundle between the execute, memory and write-back stages.
// The slave modport is the memory stage; master is the surrounding pipeline.
interface mem_stage_if;
  logic         EXE_over;
  logic [158:0] EXE_MEM_bus;
  logic         MEM_allowin;
  logic         WB_allowin;
  logic         MEM_over;
  logic [155:0] MEM_WB_bus;

  modport slave (
    input  EXE_over,
    input  EXE_MEM_bus,
    input  WB_allowin,
    output MEM_allowin,
    output MEM_over,
    output MEM_WB_bus
  );

  modport master (
    output EXE_over,
    output EXE_MEM_bus,
    output WB_allowin,
    input  MEM_allowin,
    input  MEM_over,
    input  MEM_WB_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EXE->MEM bus, drives the data RAM,
// flags misaligned accesses and aligns/extends load data for write-back.
//
// state   | meaning
// S_ENTRY | first cycle of the instruction; RAM address presented, stores write here
// S_DONE  | load data from the synchronous RAM is now valid on dm_rdata
module mem_stage (
  input  logic             clk,
  input  logic             resetn,
  mem_stage_if.slave       pipe,
  input  logic             cancel,
  output logic [31:0]      dm_addr,
  output logic [3:0]       dm_wen,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  output logic [4:0]       MEM_wdest,
  output logic [31:0]      MEM_pc
);

  typedef enum logic {S_ENTRY = 1'b0, S_DONE = 1'b1} state_t;

  state_t       state;
  state_t       state_nxt;
  logic         mem_valid;
  logic [158:0] bus_r;

  logic         load;
  logic         store;
  logic [1:0]   size;
  logic         uns;
  logic [31:0]  store_data;
  logic [31:0]  exe_result;
  logic [31:0]  lo_result;
  logic         hi_write;
  logic         lo_write;
  logic         mfhi;
  logic         mflo;
  logic         mtc0;
  logic         mfc0;
  logic [7:0]   cp0r_addr;
  logic         syscall;
  logic         eret;
  logic         brk;
  logic         fetch_error;
  logic         inst_reserved;
  logic         overflow;
  logic         wen;
  logic [4:0]   wdest;
  logic [31:0]  pc;

  assign load          = bus_r[158];
  assign store         = bus_r[157];
  assign size          = bus_r[156:155];
  assign uns           = bus_r[154];
  assign store_data    = bus_r[153:122];
  assign exe_result    = bus_r[121:90];
  assign lo_result     = bus_r[89:58];
  assign hi_write      = bus_r[57];
  assign lo_write      = bus_r[56];
  assign mfhi          = bus_r[55];
  assign mflo          = bus_r[54];
  assign mtc0          = bus_r[53];
  assign mfc0          = bus_r[52];
  assign cp0r_addr     = bus_r[51:44];
  assign syscall       = bus_r[43];
  assign eret          = bus_r[42];
  assign brk           = bus_r[41];
  assign fetch_error   = bus_r[40];
  assign inst_reserved = bus_r[39];
  assign overflow      = bus_r[38];
  assign wen           = bus_r[37];
  assign wdest         = bus_r[36:32];
  assign pc            = bus_r[31:0];

  logic        prior_exc;
  logic        misaligned;
  logic        raddr_error;
  logic        waddr_error;
  logic        mem_ok;
  logic        load_ok;
  logic        store_fire;
  logic [3:0]  wen_sel;
  logic [31:0] wdata_sel;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] mem_result;
  logic        mem_over;
  logic        mem_allowin;

  assign dm_addr = exe_result;

  assign prior_exc   = syscall | brk | fetch_error | inst_reserved | overflow;
  assign misaligned  = ((size == 2'b01) & dm_addr[0]) |
                       ((size == 2'b10) & (dm_addr[1:0] != 2'b00));
  assign raddr_error = load  & misaligned & ~prior_exc;
  assign waddr_error = store & misaligned & ~prior_exc;
  assign mem_ok      = ~prior_exc & ~raddr_error & ~waddr_error;
  assign load_ok     = load & mem_ok;

  assign mem_over    = mem_valid & (~load_ok | (state == S_DONE));
  assign mem_allowin = ~mem_valid | (mem_over & pipe.WB_allowin);

  // Writing only in S_ENTRY keeps a WB-stalled store from re-writing the RAM.
  assign store_fire = mem_valid & store & mem_ok & (state == S_ENTRY) & ~cancel;

  always_comb begin
    wen_sel   = 4'b1111;
    wdata_sel = store_data;
    case (size)
      2'b00: begin
        wen_sel   = 4'b0001 << dm_addr[1:0];
        wdata_sel = {4{store_data[7:0]}};
      end
      2'b01: begin
        wen_sel   = dm_addr[1] ? 4'b1100 : 4'b0011;
        wdata_sel = {2{store_data[15:0]}};
      end
      default: begin
        wen_sel   = 4'b1111;
        wdata_sel = store_data;
      end
    endcase
  end

  assign dm_wen   = store_fire ? wen_sel : 4'b0000;
  assign dm_wdata = wdata_sel;

  always_comb begin
    load_byte = dm_rdata[7:0];
    case (dm_addr[1:0])
      2'b00: load_byte = dm_rdata[7:0];
      2'b01: load_byte = dm_rdata[15:8];
      2'b10: load_byte = dm_rdata[23:16];
      2'b11: load_byte = dm_rdata[31:24];
      default: load_byte = dm_rdata[7:0];
    endcase
  end

  assign load_half = dm_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    load_ext = dm_rdata;
    case (size)
      2'b00:   load_ext = uns ? {24'h000000, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_ext = uns ? {16'h0000, load_half}   : {{16{load_half[15]}}, load_half};
      default: load_ext = dm_rdata;
    endcase
  end

  assign mem_result = load_ok ? load_ext : exe_result;

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = S_ENTRY;
    end else if (mem_allowin) begin
      state_nxt = S_ENTRY;
    end else if (mem_valid && state == S_ENTRY) begin
      state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_ENTRY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      bus_r     <= '0;
    end else if (cancel) begin
      mem_valid <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid <= pipe.EXE_over;
      if (pipe.EXE_over) begin
        bus_r <= pipe.EXE_MEM_bus;
      end
    end
  end

  assign pipe.MEM_allowin = mem_allowin;
  assign pipe.MEM_over    = mem_over;
  assign pipe.MEM_WB_bus  = {wen, wdest, mem_result, lo_result,
                             hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr,
                             syscall, eret, brk, fetch_error, inst_reserved,
                             raddr_error, waddr_error, overflow, dm_addr, pc};

  assign MEM_wdest = wdest & {5{mem_valid}};
  assign MEM_pc    = pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural synchronous data RAM.
module tb_mem_stage;
  logic        clk;
  logic        resetn;
  logic        cancel;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [4:0]  MEM_wdest;
  logic [31:0] MEM_pc;

  mem_stage_if pipe ();

  mem_stage dut (
    .clk       (clk),
    .resetn    (resetn),
    .pipe      (pipe),
    .cancel    (cancel),
    .dm_addr   (dm_addr),
    .dm_wen    (dm_wen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .MEM_wdest (MEM_wdest),
    .MEM_pc    (MEM_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:255];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dm_wen[k]) ram[dm_addr[9:2]][8*k +: 8] <= dm_wdata[8*k +: 8];
    end
    dm_rdata <= ram[dm_addr[9:2]];
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [155:0] got, input logic [155:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [158:0] mk_bus(input logic ld, input logic st, input logic [1:0] sz,
                                          input logic un, input logic [31:0] sdata,
                                          input logic [31:0] res, input logic ovf,
                                          input logic [4:0] wd, input logic [31:0] pcv);
    return {ld, st, sz, un, sdata, res, 32'h0, 6'b0, 8'h0, 5'b0, ovf, ~st, wd, pcv};
  endfunction

  // Presents one instruction for one accepted cycle; returns at the negedge of its entry cycle.
  task automatic issue(input logic [158:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!pipe.MEM_allowin && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_wait", 156'(n < 20), 156'(1));
    pipe.EXE_over    = 1'b1;
    pipe.EXE_MEM_bus = b;
    @(posedge clk);
    #1;
    pipe.EXE_over = 1'b0;
    @(negedge clk);
  endtask

  logic [155:0] wb;
  int           wen_cycles;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    resetn           = 1'b0;
    cancel           = 1'b0;
    pipe.EXE_over    = 1'b0;
    pipe.EXE_MEM_bus = '0;
    pipe.WB_allowin  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_allowin", 156'(pipe.MEM_allowin), 156'(1));
    check("rst_over",    156'(pipe.MEM_over),    156'(0));
    check("rst_wen",     156'(dm_wen),           156'(0));
    check("rst_wdest",   156'(MEM_wdest),        156'(0));
    check("rst_pc",      156'(MEM_pc),           156'(0));
    check("rst_wbbus",   pipe.MEM_WB_bus,        156'(0));
    resetn = 1'b1;

    // sw then lw to the same word
    issue(mk_bus(0, 1, 2'b10, 0, 32'h11223344, 32'h100, 0, 5'd0, 32'hBFC0_0000));
    check("sw_wen",   156'(dm_wen),        156'(4'b1111));
    check("sw_wdata", 156'(dm_wdata),      156'(32'h11223344));
    check("sw_over",  156'(pipe.MEM_over), 156'(1));
    issue(mk_bus(1, 0, 2'b10, 0, 32'h0, 32'h100, 0, 5'd5, 32'hBFC0_0004));
    check("lw_over_e",  156'(pipe.MEM_over), 156'(0));
    check("lw_wen_e",   156'(dm_wen),        156'(0));
    check("lw_wdest",   156'(MEM_wdest),     156'(5));
    @(negedge clk);
    wb = pipe.MEM_WB_bus;
    check("lw_over_e1", 156'(pipe.MEM_over), 156'(1));
    check("lw_result",  156'(wb[149:118]),   156'(32'h11223344));
    check("lw_wenfld",  156'(wb[155]),       156'(1));

    // sub-word loads from 0x80FFFF7F
    issue(mk_bus(0, 1, 2'b10, 0, 32'h80FFFF7F, 32'h100, 0, 5'd0, 32'h0));
    issue(mk_bus(1, 0, 2'b00, 0, 32'h0, 32'h103, 0, 5'd6, 32'h0));
    @(negedge clk);
    check("lb_result", 156'(pipe.MEM_WB_bus[149:118]), 156'(32'hFFFFFF80));
    issue(mk_bus(1, 0, 2'b00, 1, 32'h0, 32'h103, 0, 5'd6, 32'h0));
    @(negedge clk);
    check("lbu_result", 156'(pipe.MEM_WB_bus[149:118]), 156'(32'h00000080));
    issue(mk_bus(1, 0, 2'b01, 0, 32'h0, 32'h102, 0, 5'd6, 32'h0));
    @(negedge clk);
    check("lh_result", 156'(pipe.MEM_WB_bus[149:118]), 156'(32'hFFFF80FF));
    issue(mk_bus(1, 0, 2'b00, 0, 32'h0, 32'h100, 0, 5'd6, 32'h0));
    @(negedge clk);
    check("lb0_result", 156'(pipe.MEM_WB_bus[149:118]), 156'(32'h0000007F));

    // sub-word stores
    issue(mk_bus(0, 1, 2'b01, 0, 32'h0000ABCD, 32'h102, 0, 5'd0, 32'h0));
    check("sh_wen",   156'(dm_wen),   156'(4'b1100));
    check("sh_wdata", 156'(dm_wdata), 156'(32'hABCDABCD));
    issue(mk_bus(0, 1, 2'b00, 0, 32'h000000EF, 32'h101, 0, 5'd0, 32'h0));
    check("sb_wen",   156'(dm_wen),   156'(4'b0010));
    check("sb_wdata", 156'(dm_wdata), 156'(32'hEFEFEFEF));

    // address errors
    issue(mk_bus(1, 0, 2'b10, 0, 32'h0, 32'h102, 0, 5'd8, 32'h0));
    wb = pipe.MEM_WB_bus;
    check("lwerr_over",  156'(pipe.MEM_over), 156'(1));
    check("lwerr_raddr", 156'(wb[66]),        156'(1));
    check("lwerr_addr",  156'(wb[63:32]),     156'(32'h102));
    check("lwerr_res",   156'(wb[149:118]),   156'(32'h102));
    issue(mk_bus(0, 1, 2'b10, 0, 32'h12345678, 32'h101, 0, 5'd0, 32'h0));
    wb = pipe.MEM_WB_bus;
    check("swerr_waddr", 156'(wb[65]),        156'(1));
    check("swerr_raddr", 156'(wb[66]),        156'(0));
    check("swerr_wen",   156'(dm_wen),        156'(0));
    check("swerr_over",  156'(pipe.MEM_over), 156'(1));

    // store with prior overflow
    issue(mk_bus(0, 1, 2'b10, 0, 32'hDEADBEEF, 32'h104, 1, 5'd0, 32'h0));
    wb = pipe.MEM_WB_bus;
    check("ovf_wen",   156'(dm_wen), 156'(0));
    check("ovf_bit",   156'(wb[64]), 156'(1));
    check("ovf_waddr", 156'(wb[65]), 156'(0));

    // back-to-back ALU results
    @(negedge clk);
    pipe.EXE_over    = 1'b1;
    pipe.EXE_MEM_bus = mk_bus(0, 0, 2'b10, 0, 32'h0, 32'hCAFE0001, 0, 5'd3, 32'h400);
    @(posedge clk);
    #1;
    pipe.EXE_MEM_bus = mk_bus(0, 0, 2'b10, 0, 32'h0, 32'hCAFE0002, 0, 5'd4, 32'h404);
    @(negedge clk);
    check("b2b_over0", 156'(pipe.MEM_over),               156'(1));
    check("b2b_pc0",   156'(MEM_pc),                      156'(32'h400));
    check("b2b_res0",  156'(pipe.MEM_WB_bus[149:118]),    156'(32'hCAFE0001));
    @(posedge clk);
    #1;
    pipe.EXE_over = 1'b0;
    @(negedge clk);
    check("b2b_over1", 156'(pipe.MEM_over), 156'(1));
    check("b2b_pc1",   156'(MEM_pc),        156'(32'h404));
    check("b2b_wdest", 156'(MEM_wdest),     156'(4));

    // store cancelled while in MEM
    issue(mk_bus(0, 1, 2'b10, 0, 32'h99999999, 32'h108, 0, 5'd0, 32'h0));
    cancel = 1'b1;
    #1;
    check("cancel_wen", 156'(dm_wen), 156'(0));
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_over",    156'(pipe.MEM_over),    156'(0));
    check("cancel_allowin", 156'(pipe.MEM_allowin), 156'(1));
    check("cancel_ram",     156'(ram[8'h42]),       156'(32'h0));

    // store held by WB_allowin=0
    pipe.WB_allowin = 1'b0;
    issue(mk_bus(0, 1, 2'b10, 0, 32'h00000055, 32'h10C, 0, 5'd0, 32'h0));
    wen_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (dm_wen != 4'b0000) wen_cycles++;
      if (i == 1) check("stall_allowin", 156'(pipe.MEM_allowin), 156'(0));
      if (i < 3) @(negedge clk);
    end
    check("stall_over", 156'(pipe.MEM_over), 156'(1));
    pipe.WB_allowin = 1'b1;
    @(negedge clk);
    check("stall_wencnt", 156'(wen_cycles),      156'(1));
    check("stall_drain",  156'(pipe.MEM_over),   156'(0));
    check("stall_ram",    156'(ram[8'h43]),      156'(32'h00000055));

    // cancel together with EXE_over
    @(negedge clk);
    pipe.EXE_over    = 1'b1;
    pipe.EXE_MEM_bus = mk_bus(0, 0, 2'b10, 0, 32'h0, 32'h1234, 0, 5'd7, 32'h500);
    cancel           = 1'b1;
    @(posedge clk);
    #1;
    pipe.EXE_over = 1'b0;
    cancel        = 1'b0;
    @(negedge clk);
    check("cxl_over",    156'(pipe.MEM_over),    156'(0));
    check("cxl_allowin", 156'(pipe.MEM_allowin), 156'(1));
    check("cxl_wdest",   156'(MEM_wdest),        156'(0));

    // reset in the middle of a load
    issue(mk_bus(1, 0, 2'b10, 0, 32'h0, 32'h100, 0, 5'd9, 32'h600));
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rstld_over",    156'(pipe.MEM_over),    156'(0));
    check("rstld_allowin", 156'(pipe.MEM_allowin), 156'(1));
    check("rstld_wen",     156'(dm_wen),           156'(0));
    check("rstld_wbbus",   pipe.MEM_WB_bus,        156'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end
endmodule
